// File: rtl/writeback_stage.sv
// writeback_stage: final pipeline stage. Non-load results retire and write the
// register file one cycle after acceptance; loads wait in WAIT_LOAD for the
// data-memory response, then write the extracted, size/sign-adjusted value.
// All register-file outputs are registered so a negedge-sampling register
// file sees them stable mid-cycle.
// Optional feature: define WB_INSTRET_COUNTER_EN to build the 64-bit
// retired-instruction counter; otherwise instret_o is tied to zero.
module writeback_stage #(
  parameter int XLEN = 64
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            valid_i,
  output logic            ready_o,
  input  logic [4:0]      rd_idx_i,
  input  logic [XLEN-1:0] result_i,
  input  logic            is_load_i,
  input  logic [2:0]      load_funct3_i,
  input  logic [2:0]      addr_lsb_i,
  input  logic            dmem_rvalid_i,
  input  logic [XLEN-1:0] dmem_rdata_i,
  output logic            rf_wr_en_o,
  output logic [4:0]      rf_rd_idx_o,
  output logic [XLEN-1:0] rf_wr_data_o,
  output logic            retire_o,
  output logic [63:0]     instret_o
);

  typedef enum logic {
    IDLE      = 1'b0,
    WAIT_LOAD = 1'b1
  } state_t;

  state_t          state;
  logic [4:0]      pend_rd;
  logic [2:0]      pend_funct3;
  logic [2:0]      pend_lsb;
  logic [XLEN-1:0] load_data;
  logic            accept;
  logic            retire_d;

  // Shift the doubleword down to the addressed byte (zeros fill from the top,
  // so misaligned accesses read zero past bit 63), then size and extend.
  function automatic logic [XLEN-1:0] extract_load(
    input logic [XLEN-1:0] rdata,
    input logic [2:0]      funct3,
    input logic [2:0]      lsb
  );
    logic [XLEN-1:0] s;
    s = rdata >> {lsb, 3'b000};
    case (funct3)
      3'b000:  return {{(XLEN-8){s[7]}},   s[7:0]};
      3'b001:  return {{(XLEN-16){s[15]}}, s[15:0]};
      3'b010:  return {{(XLEN-32){s[31]}}, s[31:0]};
      3'b100:  return {{(XLEN-8){1'b0}},   s[7:0]};
      3'b101:  return {{(XLEN-16){1'b0}},  s[15:0]};
      3'b110:  return {{(XLEN-32){1'b0}},  s[31:0]};
      default: return s;
    endcase
  endfunction

  // Ready is a pure function of state so the upstream stage sees it at once.
  assign ready_o = (state == IDLE);
  assign accept  = valid_i && ready_o;

  // Combinational retire decision, shared by the FSM and the counter.
  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path can leave it unassigned and infer a latch.
    retire_d  = 1'b0;
    load_data = extract_load(dmem_rdata_i, pend_funct3, pend_lsb);
    if (accept && !is_load_i)                 retire_d = 1'b1;
    if (state == WAIT_LOAD && dmem_rvalid_i)  retire_d = 1'b1;
  end

  // Stage FSM with registered register-file and retire outputs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      // NOTE: captured load fields are reset too; not functionally required, but it keeps them deterministic after reset.
      state        <= IDLE;
      pend_rd      <= '0;
      pend_funct3  <= '0;
      pend_lsb     <= '0;
      rf_wr_en_o   <= 1'b0;
      rf_rd_idx_o  <= '0;
      rf_wr_data_o <= '0;
      retire_o     <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments throughout, so every register samples pre-edge values regardless of statement order.
      rf_wr_en_o <= 1'b0;
      retire_o   <= retire_d;
      case (state)
        IDLE: begin
          if (accept) begin
            if (is_load_i) begin
              state       <= WAIT_LOAD;
              pend_rd     <= rd_idx_i;
              pend_funct3 <= load_funct3_i;
              pend_lsb    <= addr_lsb_i;
            end else if (rd_idx_i != 5'd0) begin
              rf_wr_en_o   <= 1'b1;
              rf_rd_idx_o  <= rd_idx_i;
              rf_wr_data_o <= result_i;
            end
          end
        end
        WAIT_LOAD: begin
          if (dmem_rvalid_i) begin
            state <= IDLE;
            if (pend_rd != 5'd0) begin
              rf_wr_en_o   <= 1'b1;
              rf_rd_idx_o  <= pend_rd;
              rf_wr_data_o <= load_data;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef WB_INSTRET_COUNTER_EN
  // Retired-instruction counter, updated on the same edge that raises retire_o.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)       instret_o <= '0;
    else if (retire_d) instret_o <= instret_o + 64'd1;
  end
`else
  assign instret_o = '0;
`endif

endmodule

// File: tb/tb_writeback_stage.sv
// Self-checking bench for writeback_stage: directed scenarios followed by
// randomized loads and non-loads, checked against a transaction-level model.
module tb_writeback_stage;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        valid_i;
  logic        ready_o;
  logic [4:0]  rd_idx_i;
  logic [63:0] result_i;
  logic        is_load_i;
  logic [2:0]  load_funct3_i;
  logic [2:0]  addr_lsb_i;
  logic        dmem_rvalid_i;
  logic [63:0] dmem_rdata_i;
  logic        rf_wr_en_o;
  logic [4:0]  rf_rd_idx_o;
  logic [63:0] rf_wr_data_o;
  logic        retire_o;
  logic [63:0] instret_o;

  int tests  = 0;
  int errors = 0;

  // Model state: last written index/data and count of retired instructions.
  logic [4:0]  m_idx;
  logic [63:0] m_data;
  logic [63:0] m_count;

  writeback_stage #(.XLEN(64)) dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .valid_i       (valid_i),
    .ready_o       (ready_o),
    .rd_idx_i      (rd_idx_i),
    .result_i      (result_i),
    .is_load_i     (is_load_i),
    .load_funct3_i (load_funct3_i),
    .addr_lsb_i    (addr_lsb_i),
    .dmem_rvalid_i (dmem_rvalid_i),
    .dmem_rdata_i  (dmem_rdata_i),
    .rf_wr_en_o    (rf_wr_en_o),
    .rf_rd_idx_o   (rf_rd_idx_o),
    .rf_wr_data_o  (rf_wr_data_o),
    .retire_o      (retire_o),
    .instret_o     (instret_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, want $finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%016h, want 0x%016h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] exp_instret();
`ifdef WB_INSTRET_COUNTER_EN
    return m_count;
`else
    return 64'd0;
`endif
  endfunction

  // Byte-level reference: gather the addressed bytes (zero beyond byte 7),
  // then sign-fill for the signed sizes.
  function automatic logic [63:0] ref_load(input logic [63:0] d, input logic [2:0] f3,
                                           input logic [2:0] lsb);
    int          size;
    int          pos;
    logic [63:0] v;
    case (f3[1:0])
      2'd0:    size = 1;
      2'd1:    size = 2;
      2'd2:    size = 4;
      default: size = 8;
    endcase
    v = 64'd0;
    for (int i = 0; i < size; i++) begin
      pos = int'(lsb) + i;
      if (pos < 8) v[8*i +: 8] = d[8*pos +: 8];
    end
    if (!f3[2] && size < 8 && v[8*size-1])
      for (int i = 8*size; i < 64; i++) v[i] = 1'b1;
    return v;
  endfunction

  // Model update for one retired instruction.
  task automatic model_retire(input logic [4:0] rd, input logic [63:0] data);
    if (rd != 5'd0) begin
      m_idx  = rd;
      m_data = data;
    end
    m_count = m_count + 64'd1;
  endtask

  task automatic check_outs(input string tag, input logic exp_en, input logic exp_ret);
    check({tag, "_en"},      64'(rf_wr_en_o),  64'(exp_en));
    check({tag, "_idx"},     64'(rf_rd_idx_o), 64'(m_idx));
    check({tag, "_data"},    rf_wr_data_o,     m_data);
    check({tag, "_retire"},  64'(retire_o),    64'(exp_ret));
    check({tag, "_instret"}, instret_o,        exp_instret());
  endtask

  task automatic model_reset();
    m_idx   = 5'd0;
    m_data  = 64'd0;
    m_count = 64'd0;
  endtask

  // Junk on the instruction inputs while the stage must not accept.
  task automatic drive_junk();
    valid_i       = 1'($urandom);
    is_load_i     = 1'($urandom);
    rd_idx_i      = 5'($urandom);
    result_i      = {$urandom, $urandom};
    load_funct3_i = 3'($urandom);
    addr_lsb_i    = 3'($urandom);
  endtask

  task automatic do_nonload(input logic [4:0] rd, input logic [63:0] res);
    @(negedge clk_i);
    check("nl_ready", 64'(ready_o), 64'd1);
    valid_i       = 1'b1;
    is_load_i     = 1'b0;
    rd_idx_i      = rd;
    result_i      = res;
    load_funct3_i = 3'($urandom);
    addr_lsb_i    = 3'($urandom);
    dmem_rvalid_i = 1'($urandom);      // ignored in IDLE
    dmem_rdata_i  = {$urandom, $urandom};
    @(posedge clk_i); #1;
    valid_i       = 1'b0;
    dmem_rvalid_i = 1'b0;
    model_retire(rd, res);
    check_outs("nl", rd != 5'd0, 1'b1);
  endtask

  task automatic do_load(input logic [4:0] rd, input logic [2:0] f3, input logic [2:0] lsb,
                         input logic [63:0] rdata, input int delay);
    @(negedge clk_i);
    check("ld_ready", 64'(ready_o), 64'd1);
    valid_i       = 1'b1;
    is_load_i     = 1'b1;
    rd_idx_i      = rd;
    result_i      = {$urandom, $urandom};
    load_funct3_i = f3;
    addr_lsb_i    = lsb;
    dmem_rvalid_i = 1'b0;
    @(posedge clk_i); #1;
    check_outs("ld_acc", 1'b0, 1'b0);
    for (int i = 0; i < delay; i++) begin
      @(negedge clk_i);
      drive_junk();
      dmem_rvalid_i = 1'b0;
      dmem_rdata_i  = {$urandom, $urandom};
      check("ld_wait_ready", 64'(ready_o), 64'd0);
      @(posedge clk_i); #1;
      check("ld_wait_en", 64'(rf_wr_en_o), 64'd0);
      check("ld_wait_ret", 64'(retire_o), 64'd0);
    end
    @(negedge clk_i);
    drive_junk();
    dmem_rvalid_i = 1'b1;
    dmem_rdata_i  = rdata;
    check("ld_resp_ready", 64'(ready_o), 64'd0);
    @(posedge clk_i); #1;
    valid_i       = 1'b0;
    dmem_rvalid_i = 1'b0;
    model_retire(rd, ref_load(rdata, f3, lsb));
    check_outs("ld", rd != 5'd0, 1'b1);
  endtask

  initial begin
    model_reset();
    rst_ni        = 1'b0;
    valid_i       = 1'b0;
    is_load_i     = 1'b0;
    rd_idx_i      = '0;
    result_i      = '0;
    load_funct3_i = '0;
    addr_lsb_i    = '0;
    dmem_rvalid_i = 1'b0;
    dmem_rdata_i  = '0;
    #3;
    check_outs("rst", 1'b0, 1'b0);
    check("rst_ready", 64'(ready_o), 64'd1);
    @(negedge clk_i);
    rst_ni = 1'b1;

    // Directed scenarios.
    do_nonload(5'd5, 64'h1234);
    do_load(5'd7, 3'b000, 3'd3, 64'h00000000_80000000, 2);
    check("lb_value", rf_wr_data_o, 64'hFFFFFFFF_FFFFFF80);
    do_load(5'd9, 3'b110, 3'd4, 64'hDEADBEEF_00000000, 0);
    check("lwu_value", rf_wr_data_o, 64'h00000000_DEADBEEF);
    do_nonload(5'd0, 64'hFF);
    for (int i = 0; i < 4; i++) do_nonload(5'(i + 1), 64'(i * 64'h1111 + 64'h10));

    // Reset while a load is pending discards it.
    @(negedge clk_i);
    valid_i       = 1'b1;
    is_load_i     = 1'b1;
    rd_idx_i      = 5'd3;
    load_funct3_i = 3'b011;
    addr_lsb_i    = 3'd0;
    @(posedge clk_i); #1;
    valid_i = 1'b0;
    check("rstld_ready_busy", 64'(ready_o), 64'd0);
    #2;
    rst_ni = 1'b0;
    model_reset();
    #1;
    check_outs("rstld", 1'b0, 1'b0);
    check("rstld_ready", 64'(ready_o), 64'd1);
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(negedge clk_i);
    dmem_rvalid_i = 1'b1;
    dmem_rdata_i  = 64'hFFFF_FFFF_FFFF_FFFF;
    @(posedge clk_i); #1;
    dmem_rvalid_i = 1'b0;
    check_outs("rstld_after", 1'b0, 1'b0);
    check("rstld_after_ready", 64'(ready_o), 64'd1);

    // Randomized mix.
    for (int n = 0; n < 200; n++) begin
      logic [4:0] rd;
      rd = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
      if ($urandom_range(0, 1) == 1)
        do_load(rd, 3'($urandom), 3'($urandom), {$urandom, $urandom}, int'($urandom_range(0, 3)));
      else
        do_nonload(rd, {$urandom, $urandom});
    end

    // Idle cycle: pulses must have dropped and data must hold.
    @(negedge clk_i);
    @(posedge clk_i); #1;
    check_outs("idle", 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
